uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin scheduler that shares one `uart_tx` transmitter among `N_REQ` byte requesters. It latches the granted byte and drives `uart_tx`'s `tx_ready`/`tx_data_i` handshake. It tracks frame progress through `tx_idle` and `tx_bits_ok` and enforces an inter-frame gap before the next grant. It sits between the system-side producers and `uart_tx`, replacing direct `tx_ready` drive.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width
- `GAP_CYC`, 32, idle sys_clk cycles inserted after each frame (0 allowed)
- `START_TO`, 1024, max cycles `tx_ready` is held waiting for `tx_idle` to fall before abort
- `sys_clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  per-requester request, level; data must be stable while high
- `req_data`  in  N_REQ*DATA_W  requester i's byte at bits [i*DATA_W +: DATA_W]
- `ack`  out  N_REQ  one-hot, 1-cycle pulse: requester's byte latched
- `done`  out  N_REQ  one-hot, 1-cycle pulse: that requester's frame finished on line
- `err`  out  1  1-cycle pulse on start timeout
- `busy`  out  1  high in any state other than IDLE
- `owner`  out  3  index of current/last granted requester
- `tx_ready`  out  1  to `uart_tx.tx_ready`
- `tx_data_o`  out  DATA_W  to `uart_tx.tx_data_i`, held from grant until next grant
- `tx_idle`  in  1  from `uart_tx`, high when transmitter idle
- `tx_bits_ok`  in  1  from `uart_tx`, pulse at end of frame

## Operation
- States: IDLE, GRANT, START, WAIT_DONE, GAP.
- IDLE: `busy`=0. Any `req` bit high and `tx_idle`=1 -> GRANT next cycle.
- GRANT (1 cycle): select the first set `req` bit searching upward from `owner+1` modulo N_REQ, wrapping. After reset the search starts at index 0. Latch `req_data` slice into `tx_data_o`, update `owner`, pulse `ack[owner]`, go START. If `req` has dropped to all-zero by GRANT, no ack; return to IDLE.
- START: `tx_ready`=1. When `tx_idle`=0 is sampled, deassert `tx_ready` next cycle and go WAIT_DONE. Timeout counter reaching START_TO -> `tx_ready`=0, pulse `err`, go GAP, no `done`.
- WAIT_DONE: `tx_ready`=0. On `tx_bits_ok`=1, or on `tx_idle` returning to 1 (fallback), pulse `done[owner]` and go GAP.
- GAP: count GAP_CYC cycles, then go IDLE. GAP_CYC=0 passes through GAP in one cycle.
- Fairness: a requester holding `req` continuously is regranted only after every other active requester has had one frame.
- `req` changes outside GRANT are ignored. `tx_data_o` is never altered during START/WAIT_DONE.

## Timing
- Reset values: state IDLE, `tx_ready`=0, `tx_data_o`=0, `ack`=0, `done`=0, `err`=0, `busy`=0, `owner`=N_REQ-1 (so first search starts at 0), counters 0.
- `req` rise in IDLE -> `ack` 2 cycles later (IDLE->GRANT edge, GRANT registers ack). `tx_ready` rises the cycle after `ack`.
- `tx_ready` deasserts exactly 1 cycle after `tx_idle`=0 is sampled.
- `done` follows `tx_bits_ok` by 1 cycle. If `tx_bits_ok` and `tx_idle`=1 coincide, `done` pulses once.
- Frame-to-frame: next `ack` ≥ GAP_CYC+2 cycles after `done`.
- Counters are sized `$clog2(max(GAP_CYC,START_TO)+1)` bits and saturate, never wrap.
- `rst` asserted mid-frame: all outputs to reset values immediately (asynchronous). The in-flight byte is dropped without `done`.

## Structure
- State encodings and default parameter values go as `define`s in the shared `uart_defines.v`.
- One sub-module, `rr_pick`: combinational round-robin priority search taking `req` and `owner`, returning a `valid` flag and the selected index. Instantiated in GRANT logic.
- The bench instantiates `uart_tx_arb` with the real `uart_tx` and its baud generator.

## Test plan
- Single requester: `req[2]`=1, data 8'h6E -> `ack[2]` once, `tx_ready` high until `tx_idle` falls, `txd` shows 0x6E frame, `done[2]` once, `busy` low after GAP_CYC.
- All four requesting continuously with data 8'hA0..8'hA3 -> grants in order 0,1,2,3,0,… and line frames in that order, each separated by ≥GAP_CYC idle cycles.
- Rotation after reset: first grant with `req`=4'b1010 goes to 1, then 3, then 1.
- Start timeout: `tx_idle` forced high, START_TO=16 -> `err` pulse after 16 cycles in START, `tx_ready` low, no `done`, arbiter returns to IDLE.
- Reset mid-frame: assert `rst` during WAIT_DONE -> `tx_ready`=0, `busy`=0, `owner`=3 the same cycle; after release, next grant searches from 0.
- `req` withdrawn between IDLE and GRANT -> no `ack`, state returns to IDLE, `tx_ready` never asserted.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared types, defaults and sizing helper for the uart_tx arbiter
package uart_tx_arb_pkg;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_GAP_CYC  = 32;
    localparam int DEF_START_TO = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT_DONE,
        ST_GAP
    } arb_state_t;

    // One counter serves both the start timeout and the gap, so size it for the larger.
    function automatic int cnt_width(input int gap_cyc, input int start_to);
        int m;
        m = (gap_cyc > start_to) ? gap_cyc : start_to;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - handshake between the arbiter and the shared uart_tx
interface uart_tx_arb_if #(
    parameter int DATA_W = 8
);
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data_o;
    logic              tx_idle;
    logic              tx_bits_ok;

    modport master (
        output tx_ready,
        output tx_data_o,
        input  tx_idle,
        input  tx_bits_ok
    );

    modport slave (
        input  tx_ready,
        input  tx_data_o,
        output tx_idle,
        output tx_bits_ok
    );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// rtl/uart_tx_arb_rr_pick.sv - combinational round-robin search starting just above owner
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       owner,
    output logic             valid,
    output logic [2:0]       idx
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Visiting owner itself last is what keeps a continuously-requesting owner from starving others.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!valid && req[IDX_W'((int'(owner) + k) % N_REQ)]) begin
                valid = 1'b1;
                idx   = 3'((int'(owner) + k) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin scheduler sharing one uart_tx among N_REQ byte requesters
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int START_TO = DEF_START_TO
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        done,
    output logic                    err,
    output logic                    busy,
    output logic [2:0]              owner,
    uart_tx_arb_if.master           tx
);
    localparam int CNT_W = cnt_width(GAP_CYC, START_TO);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'((START_TO > 0) ? START_TO - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             pick_valid;
    logic [2:0]       pick_idx;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .owner (owner),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ack          <= '0;
            done         <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            owner        <= 3'(N_REQ - 1);
            tx.tx_ready  <= 1'b0;
            tx.tx_data_o <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req && tx.tx_idle) begin
                        state <= ST_GRANT;
                        busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (pick_valid) begin
                        owner        <= pick_idx;
                        tx.tx_data_o <= req_data[pick_idx*DATA_W +: DATA_W];
                        ack          <= N_REQ'(1) << pick_idx;
                        cnt          <= '0;
                        state        <= ST_START;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (!tx.tx_idle) begin
                        tx.tx_ready <= 1'b0;
                        state       <= ST_WAIT_DONE;
                    end else if (cnt >= START_LAST) begin
                        tx.tx_ready <= 1'b0;
                        err         <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_GAP;
                    end else begin
                        tx.tx_ready <= 1'b1;
                        cnt         <= cnt_inc;
                    end
                end
                ST_WAIT_DONE: begin
                    // tx_idle returning is a fallback in case the end-of-frame pulse is missed.
                    if (tx.tx_bits_ok || tx.tx_idle) begin
                        done  <= N_REQ'(1) << owner;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt >= GAP_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    tx.tx_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule
